counter_seq_checker: RTL and testbench
======================================

Name: counter_seq_checker

Overview:
- Single-clock checker that sits directly downstream of a free-running up-counter with synchronous reset.
- Samples the counter's output and its reset input every cycle and verifies that each value equals the previous value plus one (mod 2^WIDTH), or 0 after a counter reset.
- Counts wrap-arounds and sequence errors, and reports a sticky error flag for on-FPGA self-test of counter micro-benchmarks.

Parameters:
- WIDTH, 4, width of the observed counter value.
- ROLL_W, 8, width of the rollover counter (saturating).
- ERR_W, 4, width of the error counter (saturating).

Ports:
- clk  input  1  sole clock; same clock as the observed counter.
- rst_n  input  1  asynchronous, active-low reset.
- cnt_in  input  WIDTH  observed counter value (counter's q).
- cnt_rst  input  1  the counter's synchronous reset, sampled on the same edges as the counter.
- check_en  input  1  enables checking; 0 forces IDLE.
- clr  input  1  synchronous clear of flags and counters.
- rollover  output  1  one-cycle pulse on a detected wrap from all-ones to 0.
- roll_cnt  output  ROLL_W  number of rollovers, saturating.
- err  output  1  sticky sequence-error flag.
- err_cnt  output  ERR_W  number of mismatches, saturating.
- locked  output  1  high while in TRACK.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; rollover=0, roll_cnt=0, err=0, err_cnt=0, locked=0; internal prev=0, rst_d=0.
- All outputs are registered.
- An event detected from the sample at edge n appears on the outputs after edge n (one-cycle latency from sampling).
- Every edge: prev<=cnt_in, rst_d<=cnt_rst.
- expected = 0 if rst_d=1, else (prev+1) mod 2^WIDTH. Wrap from all-ones to 0 is legal.
- States:
  - IDLE: no compare, locked=0. check_en=1 -> SYNC.
  - SYNC: captures the first sample only, no compare. Next edge -> TRACK.
  - TRACK: locked=1, compare cnt_in vs expected.
    - Mismatch: err<=1, err_cnt+=1 (saturate at all-ones), -> ERROR.
    - Match with prev=all-ones, cnt_in=0 and rst_d=0: rollover pulses 1 cycle, roll_cnt+=1 (saturate).
    - A 0 produced by a counter reset is never a rollover.
  - ERROR: locked=0. Keeps comparing against prev (auto-resync: prev always follows cnt_in).
    - Each further mismatch: err_cnt+=1 (saturate).
    - Rollovers are still counted.
    - Leaves only via clr or check_en=0.
- check_en=0 in any state -> IDLE next edge. Counters and err hold their values; rollover=0.
- clr=1 (sync): roll_cnt=0, err_cnt=0, err=0, rollover=0; state -> SYNC if check_en=1, else IDLE.
- clr wins over a same-cycle mismatch or rollover; that sample is not counted.
- clr and check_en=0 in the same cycle: clear, then IDLE.
- Saturation: counters stop at all-ones. err stays 1.
- rst_n asserted mid-operation returns all state to reset values immediately, regardless of clk.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SYNC, TRACK, ERROR), 2-bit encoding;
  - default widths WIDTH=4, ROLL_W=8, ERR_W=4.
- One natural sub-module: sat_counter (parameterised width; inc, clr; saturating). Instantiated twice, for roll_cnt and err_cnt.
- The FSM and compare logic live in the top.

Test Plan:
1. Clean count: check_en=1, counter runs 0..15..0..15 for 40 cycles -> locked=1 from the 3rd edge, err=0, rollover pulses exactly when 0 follows 15, roll_cnt=2 after two wraps.
2. Counter reset mid-count: cnt_rst=1 while cnt_in=9, next cnt_in=0 -> no error, no rollover, roll_cnt unchanged; tracking continues 1,2,3.
3. Injected glitch: sequence 4,5,7,8 -> err=1 and err_cnt=1 one cycle after 7 is sampled, state ERROR, locked=0. The following 8 produces no extra error. Then 8,3 -> err_cnt=2.
4. Saturation: force 20 mismatches -> err_cnt=15 holds. Force 300 wraps -> roll_cnt=255 holds.
5. clr collision: clr=1 on the same cycle as a mismatch -> err=0, err_cnt=0, state SYNC, then TRACK one edge later with no error.
6. Async reset: rst_n low for 1 ns between edges while in TRACK with roll_cnt=3 -> all outputs 0 immediately. After release, IDLE; SYNC follows the next edge with check_en=1.

Source files
------------

// File: rtl/counter_seq_checker_pkg.sv
// Shared types and default widths for the counter sequence checker.
// The state encoding is fixed at 2 bits.
package counter_seq_checker_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ROLL_W = 8;
    localparam int DEF_ERR_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        ERROR = 2'd3
    } state_e;

endpackage

// File: rtl/counter_seq_checker_if.sv
// Observed-counter inputs and checker status outputs.
// The DUT side uses the slave modport.
interface counter_seq_checker_if
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ROLL_W = DEF_ROLL_W,
    parameter int ERR_W  = DEF_ERR_W
);
    logic [WIDTH-1:0]  cnt_in;
    logic              cnt_rst;
    logic              check_en;
    logic              clr;
    logic              rollover;
    logic [ROLL_W-1:0] roll_cnt;
    logic              err;
    logic [ERR_W-1:0]  err_cnt;
    logic              locked;

    modport master (
        output cnt_in, cnt_rst, check_en, clr,
        input  rollover, roll_cnt, err, err_cnt, locked
    );

    modport slave (
        input  cnt_in, cnt_rst, check_en, clr,
        output rollover, roll_cnt, err, err_cnt, locked
    );
endinterface

// File: rtl/counter_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end
endmodule

// File: rtl/counter_seq_checker.sv
// Checks that an observed counter steps by one (or restarts at 0 after its own
// reset), counting wraps and sequence errors.
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ROLL_W = DEF_ROLL_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    counter_seq_checker_if.slave  bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_e           state, state_nx;
    logic [WIDTH-1:0] prev;
    logic             rst_d;
    logic [WIDTH-1:0] expected;
    logic             compare, mismatch, wrap;
    logic             err_q, err_nx;
    logic             rollover_q, locked_q;

    assign expected = rst_d ? '0 : prev + WIDTH'(1);

    // clr and check_en=0 both suppress the sample, so nothing is counted that cycle.
    always_comb begin
        compare  = ((state == TRACK) || (state == ERROR)) && bus.check_en && !bus.clr;
        mismatch = compare && (bus.cnt_in != expected);
        wrap     = compare && !rst_d && (prev == ALL_ONES) && (bus.cnt_in == '0);
    end

    always_comb begin
        state_nx = state;
        err_nx   = err_q | mismatch;
        case (state)
            IDLE:    state_nx = SYNC;
            SYNC:    state_nx = TRACK;
            TRACK:   if (mismatch) state_nx = ERROR;
            ERROR:   state_nx = ERROR;
            default: state_nx = IDLE;
        endcase
        if (bus.clr) begin
            state_nx = SYNC;
            err_nx   = 1'b0;
        end
        if (!bus.check_en)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev       <= '0;
            rst_d      <= 1'b0;
            err_q      <= 1'b0;
            rollover_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            prev       <= bus.cnt_in;
            rst_d      <= bus.cnt_rst;
            err_q      <= err_nx;
            rollover_q <= wrap;
            locked_q   <= (state_nx == TRACK);
        end
    end

    sat_counter #(.W(ROLL_W)) u_roll_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wrap),
        .clr   (bus.clr),
        .q     (bus.roll_cnt)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mismatch),
        .clr   (bus.clr),
        .q     (bus.err_cnt)
    );

    assign bus.rollover = rollover_q;
    assign bus.err      = err_q;
    assign bus.locked   = locked_q;
endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: directed table, hand sequences, random vs model.
module tb_counter_seq_checker;
    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    counter_seq_checker_if #(.WIDTH(W), .ROLL_W(8), .ERR_W(4)) bus ();

    counter_seq_checker #(.WIDTH(W), .ROLL_W(8), .ERR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = not enabled, 1 = first sample, 2 = checking.
    int m_prev, m_phase, m_rc, m_ec;
    bit m_rst, m_in_error, m_err, m_roll;

    function automatic void model_reset();
        m_prev = 0; m_rst = 0; m_phase = 0; m_in_error = 0;
        m_rc = 0; m_ec = 0; m_err = 0; m_roll = 0;
    endfunction

    function automatic void model_update(int cnt, bit crst, bit en, bit c);
        bit chk, mis, wr;
        int exp_v;
        exp_v = m_rst ? 0 : (m_prev + 1) % (MAXV + 1);
        chk   = en && !c && (m_phase >= 2);
        mis   = chk && (cnt != exp_v);
        wr    = chk && !m_rst && (m_prev == MAXV) && (cnt == 0);
        m_roll = wr;
        if (c) begin m_rc = 0; m_ec = 0; m_err = 0; end
        if (mis) begin m_err = 1; m_in_error = 1; if (m_ec < 15) m_ec++; end
        if (wr && m_rc < 255) m_rc++;
        if (!en) begin m_phase = 0; m_in_error = 0; end
        else if (c) begin m_phase = 1; m_in_error = 0; end
        else if (m_phase < 2) m_phase++;
        m_prev = cnt;
        m_rst  = crst;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_outs(input string tag, input bit roll, input bit e, input int ec,
                            input int rc, input bit lk);
        chk({tag, " rollover"}, int'(bus.rollover), int'(roll));
        chk({tag, " err"},      int'(bus.err),      int'(e));
        chk({tag, " err_cnt"},  int'(bus.err_cnt),  ec);
        chk({tag, " roll_cnt"}, int'(bus.roll_cnt), rc);
        chk({tag, " locked"},   int'(bus.locked),   int'(lk));
    endtask

    task automatic chk_model(input string tag);
        chk_outs(tag, m_roll, m_err, m_ec, m_rc, (m_phase == 2) && !m_in_error);
    endtask

    // Drive on the falling edge, let the model see the rising edge, sample 1 unit later.
    task automatic step(input int cnt, input bit crst, input bit en, input bit c);
        @(negedge clk);
        bus.cnt_in   = W'(cnt);
        bus.cnt_rst  = crst;
        bus.check_en = en;
        bus.clr      = c;
        @(posedge clk);
        model_update(cnt, crst, en, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cnt_in = '0; bus.cnt_rst = 0; bus.check_en = 0; bus.clr = 0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int cnt; bit crst; bit en; bit c;
        bit roll; bit e; int ec; int rc; bit lk;
    } vec_t;

    vec_t tbl[21];
    int   q, cnt;
    bit   crst;

    initial begin
        tbl[0]  = '{0,  0, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{2,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{4,  0, 1, 0, 0, 1, 1, 0, 0};
        tbl[4]  = '{5,  0, 1, 0, 0, 1, 1, 0, 0};
        tbl[5]  = '{15, 0, 1, 0, 0, 1, 2, 0, 0};
        tbl[6]  = '{0,  0, 1, 0, 1, 1, 2, 1, 0};
        tbl[7]  = '{1,  0, 1, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{2,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{3,  1, 1, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{0,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{1,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{2,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{7,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{8,  0, 1, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{9,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[16] = '{3,  0, 1, 1, 0, 0, 0, 0, 0};
        tbl[17] = '{4,  0, 1, 0, 0, 0, 0, 0, 1};
        tbl[18] = '{5,  0, 0, 1, 0, 0, 0, 0, 0};
        tbl[19] = '{6,  0, 1, 0, 0, 0, 0, 0, 0};
        tbl[20] = '{7,  0, 1, 0, 0, 0, 0, 0, 1};

        do_reset();
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].cnt, tbl[i].crst, tbl[i].en, tbl[i].c);
            chk_outs($sformatf("tbl[%0d]", i), tbl[i].roll, tbl[i].e, tbl[i].ec, tbl[i].rc, tbl[i].lk);
        end

        // Clean count over two wraps.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(i % 16, 0, 1, 0);
            chk($sformatf("clean locked %0d", i), int'(bus.locked), int'(i >= 1));
            chk($sformatf("clean rollover %0d", i), int'(bus.rollover), int'(i == 16 || i == 32));
            chk($sformatf("clean err %0d", i), int'(bus.err), 0);
        end
        chk("clean roll_cnt", int'(bus.roll_cnt), 2);

        // Counter reset at 9: the following 0 is legal and not a wrap.
        step(8, 0, 1, 0);
        step(9, 1, 1, 0);
        step(0, 0, 1, 0);
        chk_outs("cntrst 0", 0, 0, 0, 2, 1);
        step(1, 0, 1, 0); step(2, 0, 1, 0); step(3, 0, 1, 0);
        chk_outs("cntrst 3", 0, 0, 0, 2, 1);

        // Glitch 4,5,7,8 then 3.
        step(3, 0, 1, 1);
        step(4, 0, 1, 0);
        step(5, 0, 1, 0);
        chk_outs("glitch 5", 0, 0, 0, 0, 1);
        step(7, 0, 1, 0);
        chk_outs("glitch 7", 0, 1, 1, 0, 0);
        step(8, 0, 1, 0);
        chk_outs("glitch 8", 0, 1, 1, 0, 0);
        step(3, 0, 1, 0);
        chk_outs("glitch 3", 0, 1, 2, 0, 0);

        // Error counter saturation.
        for (int i = 0; i < 20; i++) step((3 + 2 * (i + 1)) % 16, 0, 1, 0);
        chk("err_cnt sat", int'(bus.err_cnt), 15);
        chk("err sticky", int'(bus.err), 1);

        // Rollover counter saturation.
        step(0, 0, 1, 1);
        for (int i = 1; i < 300 * 16 + 8; i++) step(i % 16, 0, 1, 0);
        chk("roll_cnt sat", int'(bus.roll_cnt), 255);
        chk("sat no err", int'(bus.err), 0);

        // Async reset while tracking with three wraps counted.
        do_reset();
        for (int i = 0; i < 52; i++) step(i % 16, 0, 1, 0);
        chk_outs("pre async", 0, 0, 0, 3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async low", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        step(4, 0, 1, 0);
        chk_outs("async sync", 0, 0, 0, 0, 0);
        step(5, 0, 1, 0);
        chk_outs("async track", 0, 0, 0, 0, 1);

        // Random traffic against the model.
        q = 6;
        for (int i = 0; i < 3000; i++) begin
            cnt  = ($urandom_range(0, 99) < 4) ? int'($urandom_range(0, MAXV)) : q;
            crst = ($urandom_range(0, 99) < 5);
            step(cnt, crst, $urandom_range(0, 99) < 96, $urandom_range(0, 99) < 3);
            chk_model($sformatf("rand %0d", i));
            q = crst ? 0 : (cnt + 1) % (MAXV + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
